// File: rtl/peripheral_bus_pkg.sv
// Shared types and constants for the peripheral bus arbiter: FSM states,
// master ids, peripheral register addresses and the window-check helper.
package peripheral_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [31:0] LED_ADDR             = 32'h4000_000C;
    localparam logic [31:0] DIGITAL_ADDR         = 32'h4000_0010;
    localparam logic [31:0] SYS_CLK_COUNTER_ADDR = 32'h4000_0014;

    // Offset compare avoids overflow when base+span wraps the address space.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] span);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && (off < span);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick with lock override.
module rr_pick2
    import peripheral_bus_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 3
) (
    input  logic [1:0]        req_i,
    input  logic              last_grant_i,
    input  logic              lock_valid_i,
    input  logic              lock_id_i,
    input  logic [HOLD_W-1:0] hold_cnt_i,
    output logic              grant_o,
    output logic              valid_o,
    output logic              locked_o
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    // Winner selection: a live lock beats round-robin; ties go to the master not served last.
    always_comb begin
        grant_o  = M0;
        valid_o  = 1'b0;
        locked_o = 1'b0;
        if (lock_valid_i && req_i[lock_id_i] && (hold_cnt_i < MAX_HOLD_C)) begin
            grant_o  = lock_id_i;
            valid_o  = 1'b1;
            locked_o = 1'b1;
        end else if (req_i == 2'b11) begin
            grant_o = ~last_grant_i;
            valid_o = 1'b1;
        end else if (req_i[0]) begin
            grant_o = M0;
            valid_o = 1'b1;
        end else if (req_i[1]) begin
            grant_o = M1;
            valid_o = 1'b1;
        end else begin
            grant_o = M0;
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// Two-master arbiter for the peripheral register window: round-robin with
// bounded lock, one slave access per 3-cycle transaction, registered outputs.
module peripheral_bus_arbiter
    import peripheral_bus_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h4000_0000,
    parameter logic [31:0] ADDR_SPAN = 32'h0000_0018,
    parameter int          MAX_HOLD  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_m0_req,
    input  logic        i_m0_read,
    input  logic        i_m0_write,
    input  logic        i_m0_lock,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_write_data,
    input  logic        i_m1_req,
    input  logic        i_m1_read,
    input  logic        i_m1_write,
    input  logic        i_m1_lock,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_write_data,
    output logic        o_m0_ready,
    output logic        o_m0_error,
    output logic [31:0] o_m0_read_data,
    output logic        o_m1_ready,
    output logic        o_m1_error,
    output logic [31:0] o_m1_read_data,
    output logic [31:0] o_slv_address,
    output logic        o_slv_read,
    output logic        o_slv_write,
    output logic [31:0] o_slv_write_data,
    input  logic [31:0] i_slv_read_data
);

    localparam int                HOLD_W     = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              lock_valid_q, lock_valid_d;
    logic              lock_id_q, lock_id_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              win_q, win_d;
    logic              err_q, err_d;
    logic [31:0]       slv_addr_q, slv_addr_d;
    logic              slv_read_q, slv_read_d;
    logic              slv_write_q, slv_write_d;
    logic [31:0]       slv_wdata_q, slv_wdata_d;
    logic [1:0]        ready_q, ready_d;
    logic [1:0]        error_q, error_d;
    logic [31:0]       m0_rdata_q, m0_rdata_d;
    logic [31:0]       m1_rdata_q, m1_rdata_d;

    logic        pick_idx_s, pick_valid_s, pick_locked_s;
    logic [31:0] sel_addr_s, sel_wdata_s, rdata_s;
    logic        sel_read_s, sel_write_s, sel_in_win_s, win_lock_s;

    rr_pick2 #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) u_pick (
        .req_i        ({i_m1_req, i_m0_req}),
        .last_grant_i (last_grant_q),
        .lock_valid_i (lock_valid_q),
        .lock_id_i    (lock_id_q),
        .hold_cnt_i   (hold_cnt_q),
        .grant_o      (pick_idx_s),
        .valid_o      (pick_valid_s),
        .locked_o     (pick_locked_s)
    );

    assign sel_addr_s   = pick_idx_s ? i_m1_address    : i_m0_address;
    assign sel_wdata_s  = pick_idx_s ? i_m1_write_data : i_m0_write_data;
    assign sel_read_s   = pick_idx_s ? i_m1_read       : i_m0_read;
    assign sel_write_s  = pick_idx_s ? i_m1_write      : i_m0_write;
    assign sel_in_win_s = in_window(sel_addr_s, ADDR_BASE, ADDR_SPAN);
    assign win_lock_s   = win_q ? i_m1_lock : i_m0_lock;
    assign rdata_s      = slv_read_q ? i_slv_read_data : 32'h0;

    // Next-state and next-output logic; strobes and ready pulses default low.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        hold_cnt_d   = hold_cnt_q;
        win_d        = win_q;
        err_d        = err_q;
        slv_addr_d   = 32'h0;
        slv_read_d   = 1'b0;
        slv_write_d  = 1'b0;
        slv_wdata_d  = 32'h0;
        ready_d      = 2'b00;
        error_d      = 2'b00;
        m0_rdata_d   = 32'h0;
        m1_rdata_d   = 32'h0;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d = ACCESS;
                    win_d   = pick_idx_s;
                    err_d   = ~sel_in_win_s;
                    if (pick_locked_s) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1'b1);
                    end else begin
                        lock_valid_d = 1'b0;
                        hold_cnt_d   = HOLD_W'(1'b1);
                    end
                    // Latched fields go straight into the slave registers; write wins over read.
                    if (sel_in_win_s && (sel_read_s || sel_write_s)) begin
                        slv_addr_d  = sel_addr_s;
                        slv_write_d = sel_write_s;
                        slv_read_d  = sel_read_s & ~sel_write_s;
                        slv_wdata_d = sel_write_s ? sel_wdata_s : 32'h0;
                    end else begin
                        slv_addr_d  = 32'h0;
                        slv_write_d = 1'b0;
                        slv_read_d  = 1'b0;
                        slv_wdata_d = 32'h0;
                    end
                end else begin
                    lock_valid_d = 1'b0;
                    hold_cnt_d   = '0;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (win_q == M1) begin
                    ready_d[1] = 1'b1;
                    error_d[1] = err_q;
                    m1_rdata_d = rdata_s;
                end else begin
                    ready_d[0] = 1'b1;
                    error_d[0] = err_q;
                    m0_rdata_d = rdata_s;
                end
            end
            RESP: begin
                state_d      = IDLE;
                last_grant_d = win_q;
                if (win_lock_s && (hold_cnt_q < MAX_HOLD_C)) begin
                    lock_valid_d = 1'b1;
                    lock_id_d    = win_q;
                end else begin
                    lock_valid_d = 1'b0;
                    hold_cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= M1;
            lock_valid_q <= 1'b0;
            lock_id_q    <= M0;
            hold_cnt_q   <= '0;
            win_q        <= M0;
            err_q        <= 1'b0;
            slv_addr_q   <= 32'h0;
            slv_read_q   <= 1'b0;
            slv_write_q  <= 1'b0;
            slv_wdata_q  <= 32'h0;
            ready_q      <= 2'b00;
            error_q      <= 2'b00;
            m0_rdata_q   <= 32'h0;
            m1_rdata_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            hold_cnt_q   <= hold_cnt_d;
            win_q        <= win_d;
            err_q        <= err_d;
            slv_addr_q   <= slv_addr_d;
            slv_read_q   <= slv_read_d;
            slv_write_q  <= slv_write_d;
            slv_wdata_q  <= slv_wdata_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign o_m0_ready       = ready_q[0];
    assign o_m1_ready       = ready_q[1];
    assign o_m0_error       = error_q[0];
    assign o_m1_error       = error_q[1];
    assign o_m0_read_data   = m0_rdata_q;
    assign o_m1_read_data   = m1_rdata_q;
    assign o_slv_address    = slv_addr_q;
    assign o_slv_read       = slv_read_q;
    assign o_slv_write      = slv_write_q;
    assign o_slv_write_data = slv_wdata_q;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Bench for peripheral_bus_arbiter: table vectors, directed corner sequences
// and random traffic against a transaction-timeline reference model.
module tb_peripheral_bus_arbiter;

    localparam longint BASE     = 64'h4000_0000;
    localparam longint SPAN     = 64'h18;
    localparam int     MAX_HOLD = 4;

    logic        clk, reset;
    logic        m_req [2];
    logic        m_rd  [2];
    logic        m_wr  [2];
    logic        m_lock[2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata[2];
    logic [31:0] slv_rdata;

    logic        o_m0_ready, o_m0_error, o_m1_ready, o_m1_error;
    logic [31:0] o_m0_read_data, o_m1_read_data;
    logic [31:0] o_slv_address, o_slv_write_data;
    logic        o_slv_read, o_slv_write;

    peripheral_bus_arbiter dut (
        .clk (clk), .reset (reset),
        .i_m0_req (m_req[0]), .i_m0_read (m_rd[0]), .i_m0_write (m_wr[0]), .i_m0_lock (m_lock[0]),
        .i_m0_address (m_addr[0]), .i_m0_write_data (m_wdata[0]),
        .i_m1_req (m_req[1]), .i_m1_read (m_rd[1]), .i_m1_write (m_wr[1]), .i_m1_lock (m_lock[1]),
        .i_m1_address (m_addr[1]), .i_m1_write_data (m_wdata[1]),
        .o_m0_ready (o_m0_ready), .o_m0_error (o_m0_error), .o_m0_read_data (o_m0_read_data),
        .o_m1_ready (o_m1_ready), .o_m1_error (o_m1_error), .o_m1_read_data (o_m1_read_data),
        .o_slv_address (o_slv_address), .o_slv_read (o_slv_read), .o_slv_write (o_slv_write),
        .o_slv_write_data (o_slv_write_data), .i_slv_read_data (slv_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: one transaction at a time, placed on a timeline
    // (grant edge g, slave cycle g, ready cycle g+1, release at edge g+2).
    bit          act = 1'b0;
    int          g = 0, win = 0, lock_own = -1, hold = 0, last = 1;
    bit          x_rd, x_wr, x_inwin;
    logic [31:0] e_slv_addr, e_slv_wdata;
    logic        e_slv_rd, e_slv_wr;
    logic        e_rdy[2];
    logic        e_err[2];
    logic [31:0] e_rdata[2];
    bit          done[2];
    logic [31:0] addr_tbl[8];

    typedef struct {
        logic        m;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] srd;
        logic        ex_rd;
        logic        ex_wr;
        logic        ex_err;
        logic [31:0] ex_rdata;
    } vec_t;
    vec_t tbl[8];

    int order[$];
    int tready[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, got, want);
        end
    endtask

    task automatic set_req(input int m, input logic req, input logic rd, input logic wr,
                           input logic lock, input logic [31:0] addr, input logic [31:0] wdata);
        m_req[m] = req; m_rd[m] = rd; m_wr[m] = wr; m_lock[m] = lock;
        m_addr[m] = addr; m_wdata[m] = wdata;
    endtask

    function automatic bit in_win(input logic [31:0] a);
        longint la;
        la = longint'({32'h0, a});
        return (la >= BASE) && (la < BASE + SPAN);
    endfunction

    // Predict the effect of the coming edge, take the edge, compare every output.
    task automatic step();
        int w;
        e_slv_addr = 32'h0; e_slv_wdata = 32'h0; e_slv_rd = 1'b0; e_slv_wr = 1'b0;
        for (int m = 0; m < 2; m++) begin
            e_rdy[m] = 1'b0; e_err[m] = 1'b0; e_rdata[m] = 32'h0;
        end
        if (!reset) begin
            act = 1'b0; lock_own = -1; hold = 0; last = 1;
        end else if (act) begin
            if (cyc == g + 1) begin
                e_rdy[win]   = 1'b1;
                e_err[win]   = !x_inwin;
                e_rdata[win] = (x_inwin && x_rd && !x_wr) ? slv_rdata : 32'h0;
            end else begin
                last = win;
                if (m_lock[win] && hold < MAX_HOLD) lock_own = win;
                else begin lock_own = -1; hold = 0; end
                act = 1'b0;
            end
        end else begin
            w = -1;
            if (lock_own >= 0 && m_req[lock_own] && hold < MAX_HOLD) begin
                w = lock_own; hold++;
            end else begin
                lock_own = -1; hold = 0;
                if (m_req[0] && m_req[1]) w = 1 - last;
                else if (m_req[0]) w = 0;
                else if (m_req[1]) w = 1;
                if (w >= 0) hold = 1;
            end
            if (w >= 0) begin
                act = 1'b1; g = cyc; win = w;
                x_rd = m_rd[w]; x_wr = m_wr[w]; x_inwin = in_win(m_addr[w]);
                if (x_inwin && (x_rd || x_wr)) begin
                    e_slv_addr  = m_addr[w];
                    e_slv_wr    = x_wr;
                    e_slv_rd    = x_rd && !x_wr;
                    e_slv_wdata = x_wr ? m_wdata[w] : 32'h0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk1("slv_read",  o_slv_read,  e_slv_rd);
        chk1("slv_write", o_slv_write, e_slv_wr);
        chk("slv_addr",   o_slv_address,    e_slv_addr);
        chk("slv_wdata",  o_slv_write_data, e_slv_wdata);
        chk1("m0_ready",  o_m0_ready, e_rdy[0]);
        chk1("m0_error",  o_m0_error, e_err[0]);
        chk("m0_rdata",   o_m0_read_data, e_rdata[0]);
        chk1("m1_ready",  o_m1_ready, e_rdy[1]);
        chk1("m1_error",  o_m1_error, e_err[1]);
        chk("m1_rdata",   o_m1_read_data, e_rdata[1]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic record_grants(input int n);
        order.delete(); tready.delete();
        for (int i = 0; i < n; i++) begin
            step();
            if (o_m0_ready) begin order.push_back(0); tready.push_back(cyc); end
            if (o_m1_ready) begin order.push_back(1); tready.push_back(cyc); end
        end
    endtask

    task automatic rand_master(input int m);
        if (e_rdy[m]) begin
            done[m] = 1'b1;
        end else if (done[m] || !m_req[m]) begin
            done[m] = 1'b0;
            if ($urandom_range(0, 3) == 0) m_req[m] = 1'b0;
            else set_req(m, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 2) == 0), addr_tbl[$urandom_range(0, 7)], $urandom);
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h4000_000C, 32'h0000_00A5, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h4000_0014, 32'h0,         32'h0000_1234, 1'b1, 1'b0, 1'b0, 32'h0000_1234};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h4000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h4000_0010, 32'h1,         32'h55,        1'b0, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h4000_0010, 32'h3C,        32'h99,        1'b0, 1'b1, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h4000_0018, 32'h7,         32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h4000_0017, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h3FFF_FFFC, 32'h0,         32'h1,         1'b0, 1'b0, 1'b1, 32'h0};
        addr_tbl = '{32'h4000_0000, 32'h4000_0004, 32'h4000_000C, 32'h4000_0010,
                     32'h4000_0014, 32'h4000_0017, 32'h4000_0018, 32'h4000_0100};

        for (int m = 0; m < 2; m++) set_req(m, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        slv_rdata = 32'h0;
        do_reset();

        // Table vectors: one isolated transaction per row.
        for (int i = 0; i < 8; i++) begin
            set_req(int'(tbl[i].m), 1'b1, tbl[i].rd, tbl[i].wr, 1'b0, tbl[i].addr, tbl[i].wdata);
            slv_rdata = tbl[i].srd;
            step();
            chk1("tbl_slv_rd", o_slv_read, tbl[i].ex_rd);
            chk1("tbl_slv_wr", o_slv_write, tbl[i].ex_wr);
            chk("tbl_slv_addr", o_slv_address, (tbl[i].ex_rd || tbl[i].ex_wr) ? tbl[i].addr : 32'h0);
            chk("tbl_slv_wdata", o_slv_write_data, tbl[i].ex_wr ? tbl[i].wdata : 32'h0);
            step();
            chk1("tbl_ready", tbl[i].m ? o_m1_ready : o_m0_ready, 1'b1);
            chk1("tbl_error", tbl[i].m ? o_m1_error : o_m0_error, tbl[i].ex_err);
            chk("tbl_rdata", tbl[i].m ? o_m1_read_data : o_m0_read_data, tbl[i].ex_rdata);
            m_req[int'(tbl[i].m)] = 1'b0;
            step();
            chk1("tbl_ready_off", tbl[i].m ? o_m1_ready : o_m0_ready, 1'b0);
            step();
        end

        // Both masters requesting without lock: strict alternation, 3 cycles apart.
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4000_0014, 32'h0);
        set_req(1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4000_0010, 32'h0);
        slv_rdata = 32'h0000_0042;
        record_grants(13);
        chk("alt_count_ok", 32'(order.size() >= 4), 32'd1);
        for (int i = 0; i < order.size() && i < 4; i++) begin
            chk("alt_order", 32'(order[i]), 32'(i % 2));
            if (i > 0) chk("alt_spacing", 32'(tready[i] - tready[i-1]), 32'd3);
        end

        // m0 locking against a continuously requesting m1: MAX_HOLD grants, then m1.
        for (int m = 0; m < 2; m++) set_req(m, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4000_000C, 32'h11);
        set_req(1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4000_0014, 32'h0);
        record_grants(20);
        chk("lock_count_ok", 32'(order.size() >= 5), 32'd1);
        for (int i = 0; i < order.size() && i < 5; i++)
            chk("lock_order", 32'(order[i]), (i < MAX_HOLD) ? 32'd0 : 32'd1);

        // Reset during the ACCESS cycle of an m0 write.
        for (int m = 0; m < 2; m++) set_req(m, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4000_000C, 32'h77);
        step();
        chk1("rst_pre_write", o_slv_write, 1'b1);
        reset = 1'b0;
        step();
        chk1("rst_no_ready", o_m0_ready, 1'b0);
        chk1("rst_strobe_off", o_slv_write, 1'b0);
        reset = 1'b1;
        set_req(1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4000_0014, 32'h0);
        step();
        chk1("rst_tie_m0_wins", o_slv_write, 1'b1);
        step();
        chk1("rst_m0_ready", o_m0_ready, 1'b1);
        chk1("rst_m1_waits", o_m1_ready, 1'b0);
        m_req[0] = 1'b0;
        step();
        step();
        step();
        chk1("rst_m1_ready", o_m1_ready, 1'b1);
        m_req[1] = 1'b0;
        step();

        // Random traffic against the model.
        do_reset();
        done[0] = 1'b0; done[1] = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rand_master(0);
            rand_master(1);
            slv_rdata = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
